// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared core types.
//   regbits_t : register index
//   word_t    : 32-bit datapath word
//   hzstate_t : hazard sequencer state {RUN, HALT}
//   sat_inc   : saturating 32-bit increment used by the perf counters
package cpu_types_pkg;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} hzstate_t;

  localparam word_t CNT_MAX = 32'hFFFF_FFFF;

  function automatic word_t sat_inc(word_t v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the datapath/cache side and hazard_ctrl.
//   master : datapath side (drives hit pulses and pipeline state, takes controls)
//   slave  : hazard_ctrl side
//   Inputs : ihit, dhit, exmem_dMemREN/WEN, exmem_branchTaken, idex_MemRead,
//            idex_rt, ifid_rs, ifid_rt, ifid_usesRt, memwb_Halt
//   Outputs: pc_WEN, {ifid,idex,exmem,memwb}_{writeEN,flush}, halt,
//            stall_cnt/flush_cnt/lu_cnt when HAZARD_PERF_EN is defined
interface hazard_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit, dhit;
  logic     exmem_dMemREN, exmem_dMemWEN, exmem_branchTaken;
  logic     idex_MemRead;
  regbits_t idex_rt, ifid_rs, ifid_rt;
  logic     ifid_usesRt, memwb_Halt;

  logic     pc_WEN;
  logic     ifid_writeEN, ifid_flush, idex_writeEN, idex_flush;
  logic     exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush;
  logic     halt;

`ifdef HAZARD_PERF_EN
  word_t    stall_cnt, flush_cnt, lu_cnt;

  modport master (
    output ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_branchTaken,
           idex_MemRead, idex_rt, ifid_rs, ifid_rt, ifid_usesRt, memwb_Halt,
    input  pc_WEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
           exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush, halt,
           stall_cnt, flush_cnt, lu_cnt
  );
  modport slave (
    input  ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_branchTaken,
           idex_MemRead, idex_rt, ifid_rs, ifid_rt, ifid_usesRt, memwb_Halt,
    output pc_WEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
           exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush, halt,
           stall_cnt, flush_cnt, lu_cnt
  );
`else
  modport master (
    output ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_branchTaken,
           idex_MemRead, idex_rt, ifid_rs, ifid_rt, ifid_usesRt, memwb_Halt,
    input  pc_WEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
           exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush, halt
  );
  modport slave (
    input  ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_branchTaken,
           idex_MemRead, idex_rt, ifid_rs, ifid_rt, ifid_usesRt, memwb_Halt,
    output pc_WEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
           exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush, halt
  );
`endif
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect -- combinational load-use compare.
//   i_mem_read : load sits in ID/EX
//   i_idex_rt  : load destination
//   i_ifid_rs, i_ifid_rt, i_uses_rt : sources of the decoding instruction
//   o_lu       : decoding instruction needs the load result next cycle
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     i_mem_read,
  input  regbits_t i_idex_rt,
  input  regbits_t i_ifid_rs,
  input  regbits_t i_ifid_rt,
  input  logic     i_uses_rt,
  output logic     o_lu
);
  logic w_rs_hit, w_rt_hit;

  assign w_rs_hit = (i_ifid_rs == i_idex_rt);
  assign w_rt_hit = i_uses_rt & (i_ifid_rt == i_idex_rt);
  // $zero never carries a real dependency.
  assign o_lu     = i_mem_read & (i_idex_rt != '0) & (w_rs_hit | w_rt_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencer for the five-stage core.
//   CLK, nRST : core clock, asynchronous active-low reset
//   hz        : hazard_ctrl_if.slave (hit pulses, pipeline state in; PC/latch
//               write-enables and flushes, halt out)
// Latch controls are Mealy outputs of the inputs and registered state, so the
// latches move on the same edge that the hit is seen. Hit pulses that arrive
// while the pipe cannot advance are parked in ipend/dpend.
// Optional HAZARD_PERF_EN adds saturating stall/flush/load-use counters.
module hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  hazard_ctrl_if.slave hz
);
  hzstate_t r_state, w_state_nxt;
  logic     r_ipend, r_dpend, w_ipend_nxt, w_dpend_nxt;
  logic     w_memop, w_fetch_done, w_mem_done, w_run, w_advance, w_lu, w_branch;
  logic     w_pc_wen, w_ifid_wen, w_ifid_fl, w_idex_wen, w_idex_fl;
  logic     w_exmem_wen, w_exmem_fl, w_memwb_wen;

  hazard_detect u_detect (
    .i_mem_read (hz.idex_MemRead),
    .i_idex_rt  (hz.idex_rt),
    .i_ifid_rs  (hz.ifid_rs),
    .i_ifid_rt  (hz.ifid_rt),
    .i_uses_rt  (hz.ifid_usesRt),
    .o_lu       (w_lu)
  );

  assign w_memop      = hz.exmem_dMemREN | hz.exmem_dMemWEN;
  assign w_fetch_done = hz.ihit | r_ipend;
  assign w_mem_done   = ~w_memop | hz.dhit | r_dpend;
  assign w_branch     = hz.exmem_branchTaken;
  // nRST gates the Mealy outputs so nothing is enabled while reset is held.
  assign w_run        = nRST & (r_state == RUN);
  assign w_advance    = w_run & ~hz.memwb_Halt & w_fetch_done & w_mem_done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_ipend <= 1'b0;
      r_dpend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ipend <= w_ipend_nxt;
      r_dpend <= w_dpend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ipend_nxt = r_ipend;
    w_dpend_nxt = r_dpend;
    w_pc_wen    = 1'b0;
    w_ifid_wen  = 1'b0;
    w_ifid_fl   = 1'b0;
    w_idex_wen  = 1'b0;
    w_idex_fl   = 1'b0;
    w_exmem_wen = 1'b0;
    w_exmem_fl  = 1'b0;
    w_memwb_wen = 1'b0;
    if (r_state == RUN) begin
      if (hz.memwb_Halt) w_state_nxt = HALT;
      if (!w_advance) begin
        if (hz.ihit)           w_ipend_nxt = 1'b1;
        if (hz.dhit & w_memop) w_dpend_nxt = 1'b1;
      end else if (w_branch) begin
        // Wrong-path squash; branch wins over a load-use bubble.
        w_pc_wen    = 1'b1;
        w_ifid_wen  = 1'b1;
        w_ifid_fl   = 1'b1;
        w_idex_wen  = 1'b1;
        w_idex_fl   = 1'b1;
        w_exmem_wen = 1'b1;
        w_exmem_fl  = 1'b1;
        w_memwb_wen = 1'b1;
        w_ipend_nxt = 1'b0;
        w_dpend_nxt = 1'b0;
      end else if (w_lu) begin
        // Bubble into ID/EX; PC and IF/ID hold. The fetched word stays valid
        // for the unchanged PC, so the fetch stays recorded as done even when
        // it arrived as this cycle's single-cycle ihit pulse.
        w_idex_wen  = 1'b1;
        w_idex_fl   = 1'b1;
        w_exmem_wen = 1'b1;
        w_memwb_wen = 1'b1;
        w_ipend_nxt = 1'b1;
        w_dpend_nxt = 1'b0;
      end else begin
        w_pc_wen    = 1'b1;
        w_ifid_wen  = 1'b1;
        w_idex_wen  = 1'b1;
        w_exmem_wen = 1'b1;
        w_memwb_wen = 1'b1;
        w_ipend_nxt = 1'b0;
        w_dpend_nxt = 1'b0;
      end
    end
  end

  assign hz.pc_WEN        = w_pc_wen;
  assign hz.ifid_writeEN  = w_ifid_wen;
  assign hz.ifid_flush    = w_ifid_fl;
  assign hz.idex_writeEN  = w_idex_wen;
  assign hz.idex_flush    = w_idex_fl;
  assign hz.exmem_writeEN = w_exmem_wen;
  assign hz.exmem_flush   = w_exmem_fl;
  assign hz.memwb_writeEN = w_memwb_wen;
  assign hz.memwb_flush   = 1'b0;  // reserved for exceptions
  assign hz.halt          = (r_state == HALT);

`ifdef HAZARD_PERF_EN
  word_t r_stall_cnt, r_flush_cnt, r_lu_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (w_run & ~w_advance & ~hz.memwb_Halt) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_advance & w_branch)                r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_advance & w_lu & ~w_branch)        r_lu_cnt    <= sat_inc(r_lu_cnt);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
  assign hz.lu_cnt    = r_lu_cnt;
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the five-stage core: generates write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It arbitrates the one-cycle ihit/dhit pulses from the memory side, inserts load-use bubbles, squashes wrong-path instructions on taken branches and jumps, and freezes the core on halt. Sits between the cache interface and the pipeline latches in the datapath top level.

## Interface
- No parameters; register-index width is the shared `regbits_t`.
- CLK  in  1  core clock
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch complete (single-cycle pulse)
- dhit  in  1  data access complete (single-cycle pulse)
- exmem_dMemREN, exmem_dMemWEN  in  1 each  memory op held in EX/MEM
- exmem_branchTaken  in  1  branch resolved taken, or jump, in MEM
- idex_MemRead  in  1  load in ID/EX
- idex_rt  in  5  load destination
- ifid_rs, ifid_rt  in  5 each  sources of the decoding instruction
- ifid_usesRt  in  1  decoding instruction reads rt
- memwb_Halt  in  1  halt has reached MEM/WB
- pc_WEN  out  1
- ifid_writeEN, ifid_flush, idex_writeEN, idex_flush, exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush  out  1 each
- halt  out  1  registered; core stopped
- stall_cnt, flush_cnt, lu_cnt  out  32 each  (only with HAZARD_PERF_EN)

## Operation
- States: RUN, HALT. Reset → RUN. RUN → HALT when memwb_Halt=1. HALT is sticky until nRST.
- Pending flags: ipend, dpend (registered). They capture a hit pulse that arrives while the pipeline cannot advance.
- memop = exmem_dMemREN | exmem_dMemWEN.
- fetch_done = ihit | ipend.
- mem_done = !memop | dhit | dpend.
- advance = RUN & !memwb_Halt & fetch_done & mem_done.
- No advance: all writeEN, all flush and pc_WEN are 0.
  - ipend is set on ihit.
  - dpend is set on dhit & memop.
- Load-use (lu) = idex_MemRead & idex_rt≠0 & (ifid_rs==idex_rt | (ifid_usesRt & ifid_rt==idex_rt)).
- advance, no branch, no lu:
  - pc_WEN and every writeEN = 1; flushes 0.
  - Clear ipend and dpend.
- advance & lu & !branchTaken:
  - pc_WEN=0, ifid_writeEN=0.
  - idex_writeEN=1 with idex_flush=1 (bubble).
  - exmem_writeEN=1, memwb_writeEN=1.
  - Clear dpend. ipend is kept, because the fetched word is still valid for the unchanged PC.
- advance & branchTaken:
  - pc_WEN=1 (PC mux selects the target externally).
  - ifid_flush, idex_flush, exmem_flush = 1; memwb_writeEN=1.
  - Clear both pends.
  - Branch has priority over lu.
- memwb_flush is always 0. It is reserved for exceptions.
- HALT: every enable 0, halt=1, pends held.

## Timing
- All latch controls are combinational (Mealy) from the inputs and registered state. No added latency: the latches update on the same edge the hit is seen.
- Flush outputs assert only in advance cycles. They are never asserted without the matching writeEN.
- halt rises on the first edge after memwb_Halt=1 is sampled in RUN.
- Reset values:
  - state=RUN, ipend=dpend=0, halt=0, counters=0.
  - While nRST=0, all combinational outputs are 0.
- Reset mid-stall discards both pends. The memory side must re-issue its request.
- ihit and dhit in the same cycle with memop → advance.
- dhit with !memop is ignored; dpend is not set.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on RUN & !advance & !memwb_Halt.
  - lu_cnt increments on lu bubbles.
  - flush_cnt increments on branch flushes.
  - All three saturate at 32'hFFFF_FFFF.
- Undefined: the counters and their ports are absent. Control behaviour is identical.

## Structure
- cpu_types_pkg: `regbits_t`, `word_t`, and a new `hzstate_t` enum {RUN, HALT}.
- One sub-module, hazard_detect: combinational lu compare, split out so it can be checked in isolation.
- The FSM, pends and counters live in hazard_ctrl.

## Test plan
- Reset, then ihit every cycle with no memop → all writeEN=1 and pc_WEN=1 each cycle; flushes 0; halt=0.
- exmem_dMemREN=1, ihit at cycle 1, dhit at cycle 4 → no enables in cycles 1–3; ipend=1 from cycle 2; full advance at cycle 4; ipend=0 at cycle 5.
- dhit at cycle 2 while ihit is absent until cycle 5 → dpend=1 for cycles 3–5; advance at cycle 5 with both pends cleared.
- idex_MemRead=1, idex_rt=8, ifid_rs=8, ihit → pc_WEN=0, ifid_writeEN=0, idex_flush=1, exmem_writeEN=1. Repeat with idex_rt=0 → normal advance.
- branchTaken=1 together with lu, ihit → pc_WEN=1; ifid, idex, exmem flush=1; memwb_writeEN=1; lu_cnt unchanged and flush_cnt+1 (with HAZARD_PERF_EN).
- memwb_Halt=1 → enables 0 that cycle; halt=1 from the next edge and held; nRST low → halt=0 and state=RUN.
